// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce return path: queues nonces reported by the miner core and sends each one to the
// host as a 5-byte 8N1 UART frame (sync byte followed by the nonce, MSB first).
module golden_nonce_uart_tx #(
  parameter int unsigned BAUD_DIV        = 434,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic                       hash_clk,
  input  logic                       reset,
  input  logic                       golden_nonce_valid,
  input  logic [31:0]                golden_nonce,
  output logic                       uart_txd,
  output logic                       tx_busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int unsigned Depth  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PtrW   = FIFO_DEPTH_LOG2;
  localparam int unsigned CountW = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned CntW   = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntLoad = CntW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [31:0]       mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              fifo_full, fifo_nonempty;
  logic              push, pop, drop;
  logic              overflow_q, overflow_d;

  // Transmitter state
  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [31:0]       hold_q, hold_d;
  logic [7:0]        next_byte;
  logic              bit_done;

  assign fifo_full     = (count_q == CountW'(Depth));
  assign fifo_nonempty = (count_q != '0);
  assign bit_done      = (baud_q == '0);

  // A pop frees a slot in the same cycle, so a push against a full FIFO is still accepted.
  always_comb begin
    pop  = (state_q == StIdle) && fifo_nonempty;
    push = golden_nonce_valid && (!fifo_full || pop);
    drop = golden_nonce_valid && fifo_full && !pop;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drop takes priority over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge hash_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= golden_nonce;
    end
  end

  // Byte that follows the one currently in the stop bit.
  always_comb begin
    unique case (byte_idx_q)
      3'd0:    next_byte = hold_q[31:24];
      3'd1:    next_byte = hold_q[23:16];
      3'd2:    next_byte = hold_q[15:8];
      default: next_byte = hold_q[7:0];
    endcase
  end

  // State register
  always_ff @(posedge hash_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          hold_d     = mem_q[rd_ptr_q];
          byte_idx_d = 3'd0;
          shift_d    = SYNC_BYTE;
          baud_d     = CntLoad;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          baud_d    = CntLoad;
          state_d   = StData;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = CntLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          if (byte_idx_q < 3'd4) begin
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = next_byte;
            baud_d     = CntLoad;
            state_d    = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so reset releases the line in the same cycle.
  always_comb begin
    uart_txd = 1'b1;
    tx_busy  = 1'b1;
    unique case (state_q)
      StIdle:  tx_busy  = 1'b0;
      StStart: uart_txd = 1'b0;
      StData:  uart_txd = shift_q[0];
      StStop:  uart_txd = 1'b1;
      default: tx_busy  = 1'b0;
    endcase
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
- Host-facing return path of the miner: captures golden nonces reported by fpgaminer_top into a small FIFO.
- Serialises each nonce to the host over an 8N1 UART transmit line.
- It is the result-reporting end of the work/nonce interface: work goes in as midstate/work_data/nonce_min, and golden nonces come back out through this block.
- It runs on the hash clock, so no CDC is needed between the miner core and this block.

Parameters:
- BAUD_DIV, 434: hash_clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH_LOG2, 2: log2 of nonce FIFO depth (default 4 entries).
- SYNC_BYTE, 8'hA5: frame header byte.

Ports:
- hash_clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- golden_nonce_valid  input  1  one-cycle pulse; the nonce on golden_nonce is golden.
- golden_nonce  input  32  nonce, sampled when golden_nonce_valid=1.
- uart_txd  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is being shifted out.
- fifo_count  output  FIFO_DEPTH_LOG2+1  current number of queued nonces.
- overflow  output  1  sticky: set when a nonce was dropped because the FIFO was full.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, async):
  - uart_txd=1, tx_busy=0, fifo_count=0, overflow=0.
  - FSM returns to IDLE; FIFO pointers are zeroed.
  - A frame in flight is abandoned; the line returns high immediately.
- FIFO push:
  - On golden_nonce_valid=1 with the FIFO not full, golden_nonce is written and fifo_count increments next cycle.
  - On golden_nonce_valid=1 with the FIFO full and no pop in the same cycle, the nonce is dropped and overflow=1 next cycle.
  - A push and a pop in the same cycle are both honoured; fifo_count is unchanged. When full, this push is accepted, not dropped.
  - overflow_clr=1 clears overflow next cycle. If the same cycle also drops a nonce, set wins.
- Frame format: 5 bytes, in order SYNC_BYTE, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly BAUD_DIV cycles.
- Byte spacing: bytes follow back-to-back with no idle gap inside a frame. A frame is 50*BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count != 0, pop the head into a 32-bit holding register, set byte_idx=0, load the shift register with SYNC_BYTE, go to START. Otherwise hold uart_txd=1.
  - START: uart_txd=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: uart_txd=shift[0] for BAUD_DIV cycles per bit, shifting right. After bit 7, go to STOP.
  - STOP: uart_txd=1 for BAUD_DIV cycles. Then:
    - if byte_idx<4: increment byte_idx, load the next nonce byte, go to START;
    - else go to IDLE.
- Timing details:
  - The baud counter counts BAUD_DIV-1 down to 0 and reloads on each bit boundary.
  - bit_idx is 3 bits; byte_idx is 3 bits.
  - tx_busy=1 in all states except IDLE.
- Latency:
  - A valid pulse in cycle N gives fifo_count=1 in N+1.
  - IDLE pops in N+1.
  - uart_txd falls (start bit) in N+2, provided the FSM was idle.
- Frame separation: after STOP, at least one IDLE cycle always occurs between frames. Back-to-back frames are separated by exactly one cycle of high line.
- Inputs arriving mid-frame are only queued; the frame in progress is never altered.

Test Plan:
- BAUD_DIV=4, single pulse with golden_nonce=32'h1dac2b7c:
  - start bit 2 cycles after the pulse;
  - decoded bytes A5,1D,AC,2B,7C;
  - tx_busy high for exactly 200 cycles;
  - fifo_count returns to 0.
- Five pulses on consecutive cycles (nonces 1..5) while idle, FIFO depth 4:
  - nonce 1 is popped before nonce 5 arrives, so all five frames are sent in order;
  - overflow stays 0.
- Six pulses on consecutive cycles while a frame is in flight:
  - 4 are queued and 2 are dropped;
  - overflow=1 and fifo_count=4;
  - overflow_clr pulse returns overflow to 0.
- Full FIFO, with a push in the same cycle IDLE pops:
  - push is accepted and fifo_count stays 4;
  - overflow stays 0.
- reset driven low mid-DATA of byte 2:
  - uart_txd=1 and tx_busy=0 within the same cycle (async);
  - fifo_count=0;
  - after release, a new pulse produces a clean full frame.
- Two queued nonces:
  - exactly 1 idle-high cycle between the first frame's final stop bit and the second frame's start bit.
